pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It drives the load-enable and flush (bubble) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard sources:
- load-use hazards,
- taken branches resolved in EX,
- multi-cycle data-memory accesses issued from the EX/MEM stage.

It also keeps saturating stall/flush performance counters and flags a sticky error on a memory timeout.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, EX branch redirects and
// multi-cycle data-memory waits, with saturating stall/flush counters and a sticky timeout error.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RD,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_MEM_en,
  output logic             MEM_WB_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             in_err, mem_acc, freeze, load_use;

  always_comb begin
    in_err   = (state_q == ERR);
    mem_acc  = EX_MEM_MemRead | EX_MEM_MemWrite;
    freeze   = mem_acc & ~dmem_ready & ~in_err;
    load_use = ID_EX_MemRead & (ID_EX_RD != 5'd0) &
               ((ID_EX_RD == IF_ID_rs1) | (ID_EX_RD == IF_ID_rs2));

    dmem_req     = mem_acc & ~in_err;
    pc_en        = 1'b1;
    IF_ID_en     = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_en     = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_en    = 1'b1;
    MEM_WB_flush = 1'b0;

    if (in_err) begin
      pc_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
    end else if (freeze) begin
      // Hold everything up to EX/MEM; bubble into MEM/WB so WB never repeats.
      pc_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_en    = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_en && !in_err && stall_q != CNT_MAX) stall_q <= stall_q + CNT_ONE;
      if (IF_ID_flush && flush_q != CNT_MAX)       flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign mem_err   = in_err;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded directed bench: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against a wide-counter and a 2-bit-counter instance.
module tb_pipe_hazard_ctrl;

  // {dmem_req,pc_en,IF_ID_en,IF_ID_flush,ID_EX_en,ID_EX_flush,EX_MEM_en,MEM_WB_flush,mem_err}
  localparam logic [8:0] NORM   = 9'b011010100;
  localparam logic [8:0] NORM_R = 9'b111010100;
  localparam logic [8:0] LU     = 9'b000011100;
  localparam logic [8:0] BR     = 9'b011111100;
  localparam logic [8:0] BR_R   = 9'b111111100;
  localparam logic [8:0] FRZ    = 9'b100000010;
  localparam logic [8:0] ERRO   = 9'b000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_ex_mr = 0, ex_br = 0, ex_mr = 0, ex_mw = 0, rdy = 0;
  logic [4:0] id_ex_rd = 0, rs1 = 0, rs2 = 0;

  logic req, pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl, err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  st;
  logic req_s, pc_en_s, ifid_en_s, ifid_fl_s, idex_en_s, idex_fl_s, exmem_en_s, memwb_fl_s, err_s;
  logic [1:0]  stall_s, flush_s, st_s;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ID_EX_MemRead(id_ex_mr), .ID_EX_RD(id_ex_rd),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .EX_branch_taken(ex_br),
    .EX_MEM_MemRead(ex_mr), .EX_MEM_MemWrite(ex_mw), .dmem_ready(rdy),
    .dmem_req(req), .pc_en(pc_en), .IF_ID_en(ifid_en), .IF_ID_flush(ifid_fl),
    .ID_EX_en(idex_en), .ID_EX_flush(idex_fl), .EX_MEM_en(exmem_en),
    .MEM_WB_flush(memwb_fl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_err(err), .state(st)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_s (
    .clk(clk), .rst(rst), .ID_EX_MemRead(id_ex_mr), .ID_EX_RD(id_ex_rd),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .EX_branch_taken(ex_br),
    .EX_MEM_MemRead(ex_mr), .EX_MEM_MemWrite(ex_mw), .dmem_ready(rdy),
    .dmem_req(req_s), .pc_en(pc_en_s), .IF_ID_en(ifid_en_s), .IF_ID_flush(ifid_fl_s),
    .ID_EX_en(idex_en_s), .ID_EX_flush(idex_fl_s), .EX_MEM_en(exmem_en_s),
    .MEM_WB_flush(memwb_fl_s), .stall_cnt(stall_s), .flush_cnt(flush_s),
    .mem_err(err_s), .state(st_s)
  );

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [8:0]  o;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [1:0]  scs;
    logic [1:0]  fcs;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("outputs", e.tag, 32'({req, pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl, err}), 32'(e.o));
      chk("state", e.tag, 32'(st), 32'(e.st));
      chk("stall_cnt", e.tag, 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", e.tag, 32'(flush_cnt), 32'(e.fc));
      chk("stall_cnt_w2", e.tag, 32'(stall_s), 32'(e.scs));
      chk("flush_cnt_w2", e.tag, 32'(flush_s), 32'(e.fcs));
    end
  end

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic push(input string tag, input logic [1:0] xs, input logic [8:0] xo);
    exp_t e;
    e.tag = tag; e.st = xs; e.o = xo;
    e.sc = 16'(m_stall); e.fc = 16'(m_flush);
    e.scs = sat2(m_stall); e.fcs = sat2(m_flush);
    q.push_back(e);
  endtask

  // Called just after a rising edge: apply inputs, record expectation, advance one cycle.
  task automatic vec(input string tag, input logic a_mr, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                     input logic [4:0] a_rs2, input logic a_br, input logic a_emr, input logic a_emw,
                     input logic a_rdy, input logic [1:0] xs, input logic [8:0] xo);
    id_ex_mr = a_mr; id_ex_rd = a_rd; rs1 = a_rs1; rs2 = a_rs2;
    ex_br = a_br; ex_mr = a_emr; ex_mw = a_emw; rdy = a_rdy;
    push(tag, xs, xo);
    if (!xo[7] && xs != 2'd2) m_stall++;
    if (xo[5]) m_flush++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag, input logic [1:0] xs, input logic [8:0] xo);
    vec(tag, 0, 0, 0, 0, 0, 0, 0, 0, xs, xo);
  endtask

  // Pulse rst between clock edges and check the cleared state before any edge occurs.
  task automatic async_reset(input string tag);
    id_ex_mr = 0; id_ex_rd = 0; rs1 = 0; rs2 = 0;
    ex_br = 0; ex_mr = 0; ex_mw = 0; rdy = 0;
    #2 rst = 1'b1;
    m_stall = 0; m_flush = 0;
    push(tag, 2'd0, NORM);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle("reset_idle", 2'd0, NORM);

    vec("lu_rs2",   1, 5, 0, 5, 0, 0, 0, 0, 2'd0, LU);
    idle("after_lu", 2'd0, NORM);
    vec("lu_rd0",   1, 0, 0, 0, 0, 0, 0, 0, 2'd0, NORM);
    vec("lu_rs1",   1, 7, 7, 3, 0, 0, 0, 0, 2'd0, LU);
    vec("no_match", 1, 7, 6, 3, 0, 0, 0, 0, 2'd0, NORM);

    vec("br_over_lu", 1, 5, 5, 0, 1, 0, 0, 0, 2'd0, BR);
    idle("after_br", 2'd0, NORM);

    vec("zero_wait", 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, NORM_R);
    vec("ld_wait1",  0, 0, 0, 0, 0, 1, 0, 0, 2'd0, FRZ);
    vec("ld_wait2",  0, 0, 0, 0, 0, 1, 0, 0, 2'd1, FRZ);
    vec("ld_wait3",  0, 0, 0, 0, 0, 1, 0, 0, 2'd1, FRZ);
    vec("ld_ready",  0, 0, 0, 0, 0, 1, 0, 1, 2'd1, NORM_R);
    idle("after_ld", 2'd0, NORM);

    vec("st_br_wait1", 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, FRZ);
    vec("st_br_wait2", 0, 0, 0, 0, 1, 0, 1, 0, 2'd1, FRZ);
    vec("st_br_ready", 0, 0, 0, 0, 1, 0, 1, 1, 2'd1, BR_R);
    idle("after_st", 2'd0, NORM);

    vec("pre_rst_wait1", 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, FRZ);
    vec("pre_rst_wait2", 0, 0, 0, 0, 0, 1, 0, 0, 2'd1, FRZ);
    async_reset("async_rst");
    idle("post_rst", 2'd0, NORM);

    vec("to_wait1", 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, FRZ);
    vec("to_wait2", 0, 0, 0, 0, 0, 1, 0, 0, 2'd1, FRZ);
    vec("to_wait3", 0, 0, 0, 0, 0, 1, 0, 0, 2'd1, FRZ);
    vec("to_wait4", 0, 0, 0, 0, 0, 1, 0, 0, 2'd1, FRZ);
    vec("err_held", 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, ERRO);
    vec("err_rdy",  0, 0, 0, 0, 1, 1, 0, 1, 2'd2, ERRO);
    vec("err_lu",   1, 5, 5, 0, 0, 0, 0, 0, 2'd2, ERRO);
    idle("err_idle", 2'd2, ERRO);
    async_reset("err_rst");
    idle("post_err_rst", 2'd0, NORM);

    @(posedge clk); #1;
    chk("queue_drained", "end", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
